// File: rtl/switch_allocator.sv
// switch_allocator: wormhole output allocator with per-output round-robin arbitration and head-to-tail locks
module switch_allocator #(
  parameter int port_Num = 5,
  parameter int sel_W = $clog2(port_Num)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [port_Num-1:0]                in_Valid,
  input  logic [port_Num-1:0][sel_W-1:0]     in_Port,
  input  logic [port_Num-1:0]                in_Head,
  input  logic [port_Num-1:0]                in_Tail,
  input  logic [port_Num-1:0]                out_Ready,
  output logic [port_Num-1:0]                in_Grant,
  output logic [port_Num-1:0]                out_Valid,
  output logic [port_Num-1:0][sel_W-1:0]     xbar_Sel,
  output logic [port_Num-1:0]                out_Locked
);
  logic [port_Num-1:0] locked, req, go;
  logic [port_Num-1:0][sel_W-1:0] owner, rr_ptr, win;
  logic [sel_W-1:0] idx;
  function automatic logic [sel_W-1:0] wrap(input int v);
    return sel_W'(v >= port_Num ? v - port_Num : v);
  endfunction
  // pick a winner per output (owner when locked, round-robin head otherwise) and drive grants
  always_comb begin
    req = '0;
    win = '0;
    go = '0;
    idx = '0;
    in_Grant = '0;
    out_Valid = '0;
    xbar_Sel = '0;
    for (int o = 0; o < port_Num; o++) begin
      if (locked[o]) begin
        win[o] = owner[o];
        req[o] = in_Valid[owner[o]] && in_Port[owner[o]] == sel_W'(o) && !in_Head[owner[o]];
      end else
        for (int k = port_Num - 1; k >= 0; k--) begin
          idx = wrap(int'(rr_ptr[o]) + k);
          if (in_Valid[idx] && in_Port[idx] == sel_W'(o) && in_Head[idx]) begin
            req[o] = 1'b1;
            win[o] = idx;
          end
        end
      go[o] = rst && req[o] && out_Ready[o];
      if (go[o]) begin
        in_Grant[win[o]] = 1'b1;
        out_Valid[o] = 1'b1;
        xbar_Sel[o] = win[o];
      end
    end
  end
  // on each transfer: heads advance the pointer and claim the output, tails release it
  always_ff @(posedge clk)
    if (!rst) begin
      locked <= '0;
      owner <= '0;
      rr_ptr <= '0;
    end else
      for (int o = 0; o < port_Num; o++)
        if (go[o]) begin
          locked[o] <= !in_Tail[win[o]];
          if (!locked[o]) begin
            rr_ptr[o] <= wrap(int'(win[o]) + 1);
            owner[o] <= win[o];
          end
        end
  assign out_Locked = locked;
endmodule

// File: doc/switch_allocator.md
# switch_Allocator

- Wormhole output-port allocator for the 5-port mesh router.
- Consumes the per-input next-hop direction produced by route computation, arbitrates each output port among competing input ports, and locks a granted output to its winning input from head flit to tail flit.
- Drives the input-buffer dequeue grants and the crossbar select lines.
- Sits between the input VC buffers/route computation and the crossbar.

## Interface
Parameters:
- port_Num, 5: number of router ports. Input/output index equals the integer value of the `inout_Port` enum from `params_noc`.
- sel_W, $clog2(port_Num): width of a port index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_Valid  in  [port_Num]  input i has a flit at its buffer head.
- in_Port  in  [port_Num] x inout_Port  requested output direction for input i's flit.
- in_Head  in  [port_Num]  flit at input i is a head flit.
- in_Tail  in  [port_Num]  flit at input i is a tail flit. A single-flit packet has head=tail=1.
- out_Ready  in  [port_Num]  downstream of output o can accept a flit this cycle (credit available).
- in_Grant  out  [port_Num]  input i's flit transfers this cycle; buffer dequeues.
- out_Valid  out  [port_Num]  output o carries a flit this cycle.
- xbar_Sel  out  [port_Num] x sel_W  input index driving output o. Meaningful only when out_Valid[o]=1; otherwise 0.
- out_Locked  out  [port_Num]  output o is held by an in-flight packet.

## Operation
Per-output state:
- lock: FREE or LOCKED.
- owner[o]: sel_W bits.
- rr_Ptr[o]: sel_W bits, values 0..port_Num-1.

Request matching:
- Input i requests output o when in_Valid[i] & (in_Port[i]==o).
- Each input requests at most one output, so at most one grant per input per cycle.

FREE behaviour:
- Candidates are requesting inputs with in_Head=1.
- Winner is the first candidate scanning i = rr_Ptr[o], rr_Ptr[o]+1, … modulo port_Num.
- Grant is issued only if out_Ready[o]=1. When granted:
  - in_Grant[winner]=1, out_Valid[o]=1, xbar_Sel[o]=winner.
  - rr_Ptr[o] ← (winner+1) mod port_Num.
  - If in_Tail[winner]=1: output stays FREE.
  - Otherwise: LOCKED with owner[o] ← winner.
- A non-head flit requesting a FREE output is never granted (protocol violation; it stalls).

LOCKED behaviour:
- Only owner[o] is considered.
- Grant when the owner requests o, the owner's in_Head=0, and out_Ready[o]=1.
- A tail transfer returns the output to FREE. rr_Ptr is unchanged.
- Requests from other inputs, including heads, are ignored.
- An owner head flit while LOCKED is not granted.

Other rules:
- out_Locked[o] = (lock==LOCKED).
- out_Ready low stalls with no state change. A lock persists across any number of stall cycles.
- Reset (rst=0 at posedge), including mid-packet: all outputs FREE, owner=0, rr_Ptr=0. Combinational grant outputs are also forced to 0 while rst=0.

## Timing
- Grant path is combinational from in_* and out_Ready plus registered state: zero-cycle latency from request to grant.
- State updates on the rising clk edge of the transfer cycle.
- Tail and new head in the same cycle on one output: the tail is granted and the new head waits. The head is granted no earlier than the next cycle, under normal FREE arbitration from the updated rr_Ptr.
- Back-to-back packets from one input with no competitor: tail in cycle n, next head in cycle n+1. There are no bubble cycles.
- Independent outputs grant in parallel in the same cycle.
- Reset values of all outputs: in_Grant=0, out_Valid=0, xbar_Sel=0, out_Locked=0.

## Test plan
- **Single-flit packet:** input 0, head=tail=1, to EAST, out_Ready=1 → same-cycle in_Grant[0]=1, xbar_Sel[EAST]=0, out_Locked[EAST] stays 0, rr_Ptr[EAST]=1.
- **Round-robin contention:** inputs 1, 2, 3 send continuous single-flit heads to LOCAL from reset → grant order 1, 2, 3, 1, 2, 3 on consecutive cycles.
- **Wormhole lock:** input 4 sends a 3-flit packet to NORTH while input 2 holds a head to NORTH → grants go to 4, 4, 4. Input 2 is granted the cycle after input 4's tail. out_Locked[NORTH]=1 for exactly the two cycles between head and tail transfer.
- **Backpressure:** locked 4-flit packet with out_Ready[SOUTH] low for 3 cycles after the head → no grants during the stall, lock held, the remaining 3 flits are granted on the ready cycles.
- **Reset mid-packet:** rst=0 one cycle after a head is granted to WEST → out_Locked[WEST]=0 and all rr_Ptr=0 after reset. A new head from a different input is granted immediately.
- **Parallel grants:** inputs 0→EAST and 1→WEST request in the same cycle → both granted in the same cycle with independent xbar_Sel values.
